// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester mux2 arbiter.
package mux2_arb_pkg;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t;

    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mux2_arbiter_mux2.sv
// Existing mux2 datapath cell: y = s ? d1 : d0, WIDTH bits wide.
module mux2_arbiter_mux2 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one mux2 between two requesters.
// Optional per-requester accept counters (cnt0/cnt1) when MUX2_ARB_STATS_EN is defined.
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] d0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    output logic             ack1,
    output logic             s,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready
`ifdef MUX2_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    arb_state_t       state_q, state_d, other_st;
    logic [BW-1:0]    burst_q, burst_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] y_q, y_d, mux_y;
    logic             y_valid_q, y_valid_d;
    logic             req_cur, req_oth, accept;

    assign s   = (state_q == GNT1);
    assign gnt = {state_q == GNT1, state_q == GNT0};

    mux2_arbiter_mux2 #(.WIDTH(WIDTH)) u_mux (
        .d0 (d0),
        .d1 (d1),
        .s  (s),
        .y  (mux_y)
    );

    always_comb begin
        req_cur  = 1'b0;
        req_oth  = 1'b0;
        other_st = IDLE;
        case (state_q)
            GNT0: begin req_cur = req0; req_oth = req1; other_st = GNT1; end
            GNT1: begin req_cur = req1; req_oth = req0; other_st = GNT0; end
            default: ;
        endcase
    end

    // A word is taken only when the output slot is empty or draining this cycle; reset suppresses it.
    assign accept = (state_q != IDLE) && req_cur && (!y_valid_q || y_ready) && !reset;
    assign ack0   = accept && (state_q == GNT0);
    assign ack1   = accept && (state_q == GNT1);

    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        last_d    = last_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;

        if (y_valid_q && y_ready) y_valid_d = 1'b0;
        if (accept) begin
            y_d       = mux_y;
            y_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                burst_d = '0;
                if (req0 && req1)  state_d = last_q ? GNT0 : GNT1;
                else if (req0)     state_d = GNT0;
                else if (req1)     state_d = GNT1;
            end
            GNT0, GNT1: begin
                if (!req_cur) begin
                    state_d = req_oth ? other_st : IDLE;
                    last_d  = (state_q == GNT1);
                    burst_d = '0;
                end else if (accept) begin
                    if (burst_q == BURST_LAST) begin
                        burst_d = '0;
                        if (req_oth) begin
                            state_d = other_st;
                            last_d  = (state_q == GNT1);
                        end
                    end else begin
                        burst_d = burst_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            burst_q   <= '0;
            last_q    <= 1'b1;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            last_q    <= last_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;

`ifdef MUX2_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (ack0) cnt0_q <= sat_inc(cnt0_q);
            if (ack1) cnt1_q <= sat_inc(cnt1_q);
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule
